// File: rtl/clasificador_vc.sv
`default_nettype none
// ============================================================================
// Module   : clasificador_vc
// Brief    : Drains the main ingress FIFO into the VC0/VC1 FIFOs by class bit,
//            with head-of-line backpressure and per-VC push counters.
// Revision : 1.0 - initial release
// ============================================================================
module clasificador_vc #(
    parameter int DATA_WIDTH = 6,
    parameter int SEL_BIT    = 5,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] main_data,
    input  logic                  main_empty,
    output logic                  main_pop,
    input  logic                  VC0_almost_full,
    input  logic                  VC1_almost_full,
    output logic [DATA_WIDTH-1:0] VC0_data,
    output logic                  VC0_push,
    output logic [DATA_WIDTH-1:0] VC1_data,
    output logic                  VC1_push,
    output logic [CNT_WIDTH-1:0]  VC0_count,
    output logic [CNT_WIDTH-1:0]  VC1_count,
    output logic                  idle
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   vc0_data_q, vc0_data_d;
    logic [DATA_WIDTH-1:0]   vc1_data_q, vc1_data_d;
    logic                    vc0_push_q, vc0_push_d;
    logic                    vc1_push_q, vc1_push_d;
    logic [CNT_WIDTH-1:0]    vc0_count_q, vc0_count_d;
    logic [CNT_WIDTH-1:0]    vc1_count_q, vc1_count_d;

    logic w_tgt;
    logic w_blocked;
    logic w_pop;

    // Only the head word's target pause matters; the other VC is never consulted.
    always_comb begin
        w_tgt     = main_data[SEL_BIT];
        w_blocked = w_tgt ? VC1_almost_full : VC0_almost_full;
        w_pop     = !reset && !main_empty && !w_blocked;
    end

    always_comb begin
        state_d     = state_q;
        vc0_data_d  = vc0_data_q;
        vc1_data_d  = vc1_data_q;
        vc0_push_d  = 1'b0;
        vc1_push_d  = 1'b0;
        vc0_count_d = vc0_count_q;
        vc1_count_d = vc1_count_q;

        if (main_empty) begin
            state_d = ST_IDLE;
        end else if (w_blocked) begin
            state_d = ST_PAUSED;
        end else begin
            state_d = ST_ACTIVE;
        end

        if (w_pop && !w_tgt) begin
            vc0_data_d  = main_data;
            vc0_push_d  = 1'b1;
            vc0_count_d = vc0_count_q + CNT_WIDTH'(1);
        end
        if (w_pop && w_tgt) begin
            vc1_data_d  = main_data;
            vc1_push_d  = 1'b1;
            vc1_count_d = vc1_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            vc0_data_q  <= '0;
            vc1_data_q  <= '0;
            vc0_push_q  <= 1'b0;
            vc1_push_q  <= 1'b0;
            vc0_count_q <= '0;
            vc1_count_q <= '0;
        end else begin
            state_q     <= state_d;
            vc0_data_q  <= vc0_data_d;
            vc1_data_q  <= vc1_data_d;
            vc0_push_q  <= vc0_push_d;
            vc1_push_q  <= vc1_push_d;
            vc0_count_q <= vc0_count_d;
            vc1_count_q <= vc1_count_d;
        end
    end

    // A push already in flight is suppressed as soon as reset is raised.
    assign main_pop  = w_pop;
    assign VC0_push  = vc0_push_q && !reset;
    assign VC1_push  = vc1_push_q && !reset;
    assign VC0_data  = vc0_data_q;
    assign VC1_data  = vc1_data_q;
    assign VC0_count = vc0_count_q;
    assign VC1_count = vc1_count_q;
    assign idle      = (state_q == ST_IDLE);

endmodule
`default_nettype wire
